// File: rtl/data_memory_if.sv
// Data memory bus: word address, write data, read/write enables and read result.
// The master drives the request; the slave returns the combinational read word.
interface data_memory_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] ReadData;

    modport master (
        output Address,
        output WriteData,
        output MemRead,
        output MemWrite,
        input  ReadData
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemRead,
        input  MemWrite,
        output ReadData
    );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, zero-latency read.
// Every word is a resettable flop, so reads never return X after reset.
module data_memory #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input logic          Clk,
    input logic          Rst_n,
    data_memory_if.slave bus
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Async clear of all words; otherwise store on a write edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.MemWrite) begin
            mem[bus.Address] <= bus.WriteData;
        end
    end

    // Read port: old word until the edge, zero when disabled or in reset.
    always_comb begin
        bus.ReadData = '0;
        if (bus.MemRead && Rst_n) begin
            bus.ReadData = mem[bus.Address];
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stimulus pushes expected read words,
// a monitor samples ReadData on each check strobe and compares.
module tb_data_memory;
    logic Clk;
    logic Rst_n;

    data_memory_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    data_memory #(.ADDR_W(7), .DATA_W(32), .DEPTH(128)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    int tests;
    int failed;
    logic [31:0] exp_q [$];
    string       name_q [$];
    event        chk_ev;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Monitor: one sample of ReadData per strobe, compared against the queue head.
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(chk_ev);
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL no_expect: got %h required queued value", bus.ReadData);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (bus.ReadData !== e) begin
                    failed++;
                    $display("FAIL %s: got %h required %h", n, bus.ReadData, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] e);
        #1;
        exp_q.push_back(e);
        name_q.push_back(name);
        ->chk_ev;
        #1;
    endtask

    task automatic rd(input logic [6:0] a, input logic [31:0] e, input string name);
        @(negedge Clk);
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b1;
        bus.Address  = a;
        check(name, e);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        @(negedge Clk);
        bus.MemWrite  = 1'b1;
        bus.MemRead   = 1'b0;
        bus.Address   = a;
        bus.WriteData = d;
        @(posedge Clk);
        #1;
        bus.MemWrite = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        Rst_n         = 1'b0;
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.Address   = 7'h43;
        bus.WriteData = 32'hFFFF_FFFF;

        // Writes attempted during reset must be dropped; output held at 0.
        @(posedge Clk);
        @(posedge Clk);
        check("rst_hold_rd", 32'h0);
        @(negedge Clk);
        bus.MemWrite = 1'b0;
        Rst_n = 1'b1;

        rd(7'h43, 32'h0, "rst_then_rd");

        // Write with MemRead low: output stays zero.
        @(negedge Clk);
        bus.MemWrite  = 1'b1;
        bus.MemRead   = 1'b0;
        bus.Address   = 7'h43;
        bus.WriteData = 32'hD83F_003F;
        @(posedge Clk);
        #1;
        bus.MemWrite = 1'b0;
        check("rd_disabled", 32'h0);
        rd(7'h43, 32'hD83F_003F, "wr_then_rd");

        wr(7'h43, 32'h0);
        rd(7'h43, 32'h0, "overwrite");

        wr(7'h00, 32'hA5A5_A5A5);
        wr(7'h7F, 32'h5A5A_5A5A);
        rd(7'h00, 32'hA5A5_A5A5, "iso_lo");
        // Same cycle address change must follow combinationally.
        bus.Address = 7'h7F;
        check("iso_hi", 32'h5A5A_5A5A);
        bus.Address = 7'h43;
        check("iso_mid", 32'h0);

        // Read during write, same address.
        wr(7'h10, 32'h1);
        @(negedge Clk);
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.Address   = 7'h10;
        bus.WriteData = 32'h2;
        check("rdw_before", 32'h1);
        @(posedge Clk);
        check("rdw_after", 32'h2);
        bus.MemWrite = 1'b0;

        // Write one address while reading another.
        @(negedge Clk);
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.Address   = 7'h20;
        bus.WriteData = 32'hCAFE_F00D;
        @(posedge Clk);
        #1;
        bus.MemWrite = 1'b0;
        bus.Address  = 7'h00;
        check("indep_other", 32'hA5A5_A5A5);
        rd(7'h20, 32'hCAFE_F00D, "indep_wr");

        // Async reset between edges clears output and contents at once.
        wr(7'h43, 32'hFFFF_FFFF);
        rd(7'h43, 32'hFFFF_FFFF, "pre_async");
        #2;
        Rst_n = 1'b0;
        check("async_imm", 32'h0);
        bus.MemRead = 1'b0;
        check("async_rd_off", 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        rd(7'h43, 32'h0, "async_cleared");
        rd(7'h00, 32'h0, "async_clr_w0");
        rd(7'h7F, 32'h0, "async_clr_w7f");

        // First write after release works normally.
        wr(7'h43, 32'h1234_5678);
        rd(7'h43, 32'h1234_5678, "post_rst_wr");
        rd(7'h44, 32'h0, "post_rst_nb");

        #5;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
